// File: rtl/handshake_pkg.sv
// Shared width and data type for the valid/ready handshake demonstrator.
package handshake_pkg;

    localparam int unsigned DW = 3;

    typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/hs_stage.sv
// Single valid/ready pipeline stage. Define SKID_BUFFER_EN to get a registered
// in_ready with one skid entry; otherwise in_ready is the combinational ~full | out_ready.
module hs_stage #(
    parameter int unsigned DW = handshake_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          main_full_q, main_full_d;
    logic [DW-1:0] main_data_q, main_data_d;
    logic          in_fire;
    logic          out_fire;

`ifdef SKID_BUFFER_EN
    logic          skid_full_q, skid_full_d;
    logic [DW-1:0] skid_data_q, skid_data_d;

    assign in_ready = ~skid_full_q;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_full_q & out_ready;

    // The main entry refills from skid first, so the older word always leaves first.
    always_comb begin
        main_full_d = main_full_q;
        main_data_d = main_data_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        if (out_fire || !main_full_q) begin
            if (skid_full_q) begin
                main_full_d = 1'b1;
                main_data_d = skid_data_q;
                skid_full_d = 1'b0;
            end else if (in_fire) begin
                main_full_d = 1'b1;
                main_data_d = in_data;
            end else begin
                main_full_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_full_d = 1'b1;
            skid_data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
        end
    end
`else
    assign in_ready = ~main_full_q | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_full_q & out_ready;

    always_comb begin
        main_full_d = main_full_q;
        main_data_d = main_data_q;
        if (in_fire) begin
            main_full_d = 1'b1;
            main_data_d = in_data;
        end else if (out_fire) begin
            main_full_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_full_q <= 1'b0;
            main_data_q <= '0;
        end else begin
            main_full_q <= main_full_d;
            main_data_q <= main_data_d;
        end
    end

    assign out_valid = main_full_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/handshake_pipe_top.sv
// Source counter -> hs_stage -> result register. SKID_BUFFER_EN selects the
// skid-buffered stage variant.
module handshake_pipe_top #(
    parameter int unsigned DW = handshake_pkg::DW
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    input  logic          valid_in,
    input  logic          ready_in,
    output logic [DW-1:0] result
);

    logic [DW-1:0] src_q, src_d;
    logic [DW-1:0] result_q, result_d;
    logic          up_ready;
    logic          up_fire;
    logic          out_valid;
    logic          dn_fire;
    logic [DW-1:0] stage_data;

    hs_stage #(.DW(DW)) u_stage (
        .clk       (sys_clk),
        .rst_n     (rst_n),
        .in_valid  (valid_in),
        .in_ready  (up_ready),
        .in_data   (src_q),
        .out_valid (out_valid),
        .out_ready (ready_in),
        .out_data  (stage_data)
    );

    assign up_fire = valid_in & up_ready;
    assign dn_fire = out_valid & ready_in;

    always_comb begin
        src_d    = src_q;
        result_d = result_q;
        if (up_fire) src_d    = src_q + DW'(1);
        if (dn_fire) result_d = stage_data;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q    <= '0;
            result_q <= '0;
        end else begin
            src_q    <= src_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_handshake_pipe_top.sv
// Directed, table-driven bench for handshake_pipe_top; expectations follow
// SKID_BUFFER_EN when it is defined.
module tb_handshake_pipe_top;

    logic       sys_clk;
    logic       rst_n;
    logic       valid_in;
    logic       ready_in;
    logic [2:0] result;

    handshake_pipe_top #(.DW(3)) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .result   (result)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic       ready;
        logic [2:0] exp_result;
        logic [2:0] exp_src;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_chk;
    int   n_pass;

    function automatic void add(input logic rn, input logic v, input logic r,
                                input int res, input int src, input string nm);
        vec_t e;
        e.rst_n      = rn;
        e.valid      = v;
        e.ready      = r;
        e.exp_result = 3'(res);
        e.exp_src    = 3'(src);
        e.name       = nm;
        vecs.push_back(e);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step(input logic rn, input logic v, input logic r);
        rst_n    = rn;
        valid_in = v;
        ready_in = r;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst_n    = 1'b1;
        valid_in = 1'b1;
        ready_in = 1'b1;
        #1;

        add(0, 1, 1, 0, 0, "reset");
        add(1, 1, 1, 0, 1, "stream_e1");
        add(1, 1, 1, 0, 2, "stream_e2");
        add(1, 1, 1, 1, 3, "stream_e3");
        add(1, 1, 1, 2, 4, "stream_e4");
        add(1, 1, 1, 3, 5, "stream_e5");
        add(1, 1, 1, 4, 6, "stream_e6");
        add(1, 1, 1, 5, 7, "stream_e7");
        add(1, 1, 1, 6, 0, "src_wrap");
        add(1, 1, 1, 7, 1, "stream_e9");
        add(1, 1, 1, 0, 2, "result_wrap");
        add(1, 1, 1, 1, 3, "stream_e11");
        add(1, 0, 1, 2, 3, "drain_last");
        add(1, 0, 1, 2, 3, "idle_empty");
`ifdef SKID_BUFFER_EN
        add(1, 1, 0, 2, 4, "bp_1");
        add(1, 1, 0, 2, 5, "bp_2_skid");
        add(1, 1, 0, 2, 5, "bp_3_full");
        add(1, 0, 1, 3, 5, "bp_drain_main");
        add(1, 0, 1, 4, 5, "bp_drain_skid");
        add(1, 0, 1, 4, 5, "bp_idle_hold");
`else
        add(1, 1, 0, 2, 4, "bp_1");
        add(1, 1, 0, 2, 4, "bp_2_hold");
        add(1, 1, 0, 2, 4, "bp_3_hold");
        add(1, 0, 1, 3, 4, "bp_drain");
        add(1, 0, 1, 3, 4, "bp_idle_hold");
        add(1, 0, 1, 3, 4, "bp_idle_hold2");
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].valid, vecs[i].ready);
            chk({vecs[i].name, "_result"}, int'(result), int'(vecs[i].exp_result));
            chk({vecs[i].name, "_src"}, int'(dut.src_q), int'(vecs[i].exp_src));
        end

        // Mid-stream asynchronous reset at result=3, then restart from 0.
        step(0, 1, 1);
        chk("ms_reset_result", int'(result), 0);
        for (int k = 1; k <= 5; k++) begin
            step(1, 1, 1);
            chk("ms_stream_result", int'(result), (k < 2) ? 0 : k - 2);
            chk("ms_stream_src", int'(dut.src_q), k);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_result", int'(result), 0);
        chk("async_reset_src", int'(dut.src_q), 0);
        step(0, 1, 1);
        chk("held_reset_result", int'(result), 0);
        step(1, 1, 1);
        chk("restart_e1_result", int'(result), 0);
        chk("restart_e1_src", int'(dut.src_q), 1);
        step(1, 1, 1);
        chk("restart_e2_result", int'(result), 0);
        step(1, 1, 1);
        chk("restart_e3_result", int'(result), 1);
        chk("restart_e3_src", int'(dut.src_q), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
